// File: rtl/axis_ready_sink.sv
// AXI-Stream sink with a scheduled tready (always/oscillate/window) and beat accounting.
// Optional tdata sequence checker: define AXIS_SINK_SEQ_CHECK_EN.
module axis_ready_sink #(
  parameter int DATA_WIDTH   = 16,
  parameter int READY_POLICY = 1,
  parameter int LOW_TIME     = 1,
  parameter int HIGH_TIME    = 200,
  parameter int CHECK_STEP   = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic [31:0]           beat_count,
  output logic [DATA_WIDTH-1:0] last_tdata,
  output logic                  seq_err
);

  localparam logic [0:0]  ST_LOW  = 1'b0;
  localparam logic [0:0]  ST_HIGH = 1'b1;
  localparam logic [15:0] LOW_LD  = 16'(LOW_TIME - 1);
  localparam logic [15:0] HIGH_LD = 16'(HIGH_TIME - 1);

  // Unknown policies fall back to always-ready.
  localparam int POL =
    (READY_POLICY == 1 || READY_POLICY == 2) ? READY_POLICY : 0;

  logic [0:0]            state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  tready_q, tready_d;
  logic [31:0]           beat_count_q, beat_count_d;
  logic [DATA_WIDTH-1:0] last_tdata_q, last_tdata_d;
  logic                  acc;

  assign acc = s_axis_tvalid & tready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tready_d = tready_q;
    if (POL == 0) begin
      tready_d = 1'b1;
    end else begin
      case (state_q)
        ST_LOW: begin
          if (cnt_q == 16'd0) begin
            state_d  = ST_HIGH;
            cnt_d    = HIGH_LD;
            tready_d = 1'b1;
          end else begin
            cnt_d    = cnt_q - 16'd1;
            tready_d = 1'b0;
          end
        end
        default: begin
          tready_d = 1'b1;
          if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
          end else if (POL == 1) begin
            state_d  = ST_LOW;
            cnt_d    = LOW_LD;
            tready_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    beat_count_d = beat_count_q;
    last_tdata_d = last_tdata_q;
    if (acc) begin
      beat_count_d = beat_count_q + 32'd1;
      last_tdata_d = s_axis_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= ST_LOW;
      cnt_q        <= LOW_LD;
      tready_q     <= 1'b0;
      beat_count_q <= 32'd0;
      last_tdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tready_q     <= tready_d;
      beat_count_q <= beat_count_d;
      last_tdata_q <= last_tdata_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign beat_count    = beat_count_q;
  assign last_tdata    = last_tdata_q;

`ifdef AXIS_SINK_SEQ_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(CHECK_STEP);

  logic                  seen_q, seen_d;
  logic                  seq_err_q, seq_err_d;
  logic [DATA_WIDTH-1:0] exp_tdata;

  // The first beat after reset has no predecessor to compare against.
  always_comb begin
    exp_tdata = last_tdata_q + STEP;
    seen_d    = seen_q | acc;
    seq_err_d = seq_err_q |
      (acc & seen_q & (s_axis_tdata != exp_tdata));
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      seen_q    <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      seen_q    <= seen_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_ready_sink.sv
// Testbench for axis_ready_sink: vector table on a short schedule,
// plus long-run sequences on the default-sized instances.
module tb_axis_ready_sink;

`ifdef AXIS_SINK_SEQ_CHECK_EN
  localparam logic EN = 1'b1;
`else
  localparam logic EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tvalid = 1'b0;
  logic [15:0] tdata = 16'd0;

  always #5 clk = ~clk;

  logic        rs, r1, r2, r0, r7;
  logic [31:0] cs, c1, c2, c0, c7;
  logic [15:0] ls, l1, l2, l0, l7;
  logic        es, e1, e2, e0, e7;

  axis_ready_sink #(.DATA_WIDTH(16), .READY_POLICY(1), .LOW_TIME(2),
    .HIGH_TIME(3), .CHECK_STEP(2)) u_s (
    .aclk(clk), .aresetn(rst_n), .s_axis_tvalid(tvalid),
    .s_axis_tready(rs), .s_axis_tdata(tdata),
    .beat_count(cs), .last_tdata(ls), .seq_err(es));

  axis_ready_sink #(.DATA_WIDTH(16), .READY_POLICY(1), .LOW_TIME(1),
    .HIGH_TIME(200), .CHECK_STEP(2)) u_p1 (
    .aclk(clk), .aresetn(rst_n), .s_axis_tvalid(tvalid),
    .s_axis_tready(r1), .s_axis_tdata(tdata),
    .beat_count(c1), .last_tdata(l1), .seq_err(e1));

  axis_ready_sink #(.DATA_WIDTH(16), .READY_POLICY(2), .LOW_TIME(1),
    .HIGH_TIME(100), .CHECK_STEP(2)) u_p2 (
    .aclk(clk), .aresetn(rst_n), .s_axis_tvalid(tvalid),
    .s_axis_tready(r2), .s_axis_tdata(tdata),
    .beat_count(c2), .last_tdata(l2), .seq_err(e2));

  axis_ready_sink #(.DATA_WIDTH(16), .READY_POLICY(0), .LOW_TIME(5),
    .HIGH_TIME(5), .CHECK_STEP(2)) u_p0 (
    .aclk(clk), .aresetn(rst_n), .s_axis_tvalid(tvalid),
    .s_axis_tready(r0), .s_axis_tdata(tdata),
    .beat_count(c0), .last_tdata(l0), .seq_err(e0));

  axis_ready_sink #(.DATA_WIDTH(16), .READY_POLICY(7), .LOW_TIME(5),
    .HIGH_TIME(5), .CHECK_STEP(2)) u_p7 (
    .aclk(clk), .aresetn(rst_n), .s_axis_tvalid(tvalid),
    .s_axis_tready(r7), .s_axis_tdata(tdata),
    .beat_count(c7), .last_tdata(l7), .seq_err(e7));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst_n;
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic [31:0] cnt;
    logic [15:0] last;
    logic        err;
  } vec_t;

  vec_t vt[21];

  initial begin
    int m1, m2, m0, m7;

    // Expectations are the outputs seen just after the edge that
    // samples the row's inputs. Schedule: low 2, high 3.
    vt[0]  = '{1'b0, 1'b1, 16'd5,      1'b0, 32'd0, 16'd0,      1'b0};
    vt[1]  = '{1'b0, 1'b1, 16'd5,      1'b0, 32'd0, 16'd0,      1'b0};
    vt[2]  = '{1'b1, 1'b1, 16'd0,      1'b0, 32'd0, 16'd0,      1'b0};
    vt[3]  = '{1'b1, 1'b1, 16'd0,      1'b1, 32'd0, 16'd0,      1'b0};
    vt[4]  = '{1'b1, 1'b1, 16'd0,      1'b1, 32'd1, 16'd0,      1'b0};
    vt[5]  = '{1'b1, 1'b1, 16'd2,      1'b1, 32'd2, 16'd2,      1'b0};
    vt[6]  = '{1'b1, 1'b1, 16'd4,      1'b0, 32'd3, 16'd4,      1'b0};
    vt[7]  = '{1'b1, 1'b1, 16'd6,      1'b0, 32'd3, 16'd4,      1'b0};
    vt[8]  = '{1'b1, 1'b1, 16'd6,      1'b1, 32'd3, 16'd4,      1'b0};
    vt[9]  = '{1'b1, 1'b1, 16'd6,      1'b1, 32'd4, 16'd6,      1'b0};
    vt[10] = '{1'b1, 1'b0, 16'd7,      1'b1, 32'd4, 16'd6,      1'b0};
    vt[11] = '{1'b1, 1'b1, 16'd9,      1'b0, 32'd5, 16'd9,      EN};
    vt[12] = '{1'b1, 1'b1, 16'd11,     1'b0, 32'd5, 16'd9,      EN};
    vt[13] = '{1'b1, 1'b1, 16'd11,     1'b1, 32'd5, 16'd9,      EN};
    vt[14] = '{1'b1, 1'b1, 16'd11,     1'b1, 32'd6, 16'd11,     EN};
    vt[15] = '{1'b0, 1'b1, 16'd13,     1'b0, 32'd0, 16'd0,      1'b0};
    vt[16] = '{1'b1, 1'b1, 16'd0,      1'b0, 32'd0, 16'd0,      1'b0};
    vt[17] = '{1'b1, 1'b1, 16'd0,      1'b1, 32'd0, 16'd0,      1'b0};
    vt[18] = '{1'b1, 1'b1, 16'hFFFE,   1'b1, 32'd1, 16'hFFFE,   1'b0};
    vt[19] = '{1'b1, 1'b1, 16'h0000,   1'b1, 32'd2, 16'h0000,   1'b0};
    vt[20] = '{1'b1, 1'b0, 16'h0000,   1'b0, 32'd2, 16'h0000,   1'b0};

    #2;
    for (int i = 0; i < 21; i++) begin
      rst_n  = vt[i].rst_n;
      tvalid = vt[i].v;
      tdata  = vt[i].d;
      step();
      chk($sformatf("vec%0d_tready", i), 32'(rs), 32'(vt[i].rdy));
      chk($sformatf("vec%0d_count", i), cs, vt[i].cnt);
      chk($sformatf("vec%0d_last", i), 32'(ls), 32'(vt[i].last));
      chk($sformatf("vec%0d_err", i), 32'(es), 32'(vt[i].err));
    end

    // Policy 1, low 1 / high 200: period 201, 402 valid cycles.
    rst_n = 1'b0; tvalid = 1'b0;
    step(); step();
    rst_n = 1'b1; tvalid = 1'b1;
    m1 = 0;
    for (int k = 0; k < 402; k++) begin
      tdata = 16'(2 * k);
      if (r1 !== ((k % 201) != 0)) m1++;
      step();
    end
    tvalid = 1'b0;
    chk("p1_tready_schedule_mismatches", 32'(m1), 32'd0);
    chk("p1_beats_402", c1, 32'd400);

    // Policy 2 window, policy 0 and an unknown policy.
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1; tvalid = 1'b1;
    m2 = 0; m0 = 0; m7 = 0;
    for (int k = 0; k < 1000; k++) begin
      if (r2 !== (k != 0)) m2++;
      if (r0 !== (k != 0)) m0++;
      if (r7 !== (k != 0)) m7++;
      step();
    end
    tvalid = 1'b0;
    chk("p2_tready_mismatches", 32'(m2), 32'd0);
    chk("p0_tready_mismatches", 32'(m0), 32'd0);
    chk("p7_tready_mismatches", 32'(m7), 32'd0);
    chk("p2_beats_1000", c2, 32'd999);
    chk("p0_beats_1000", c0, 32'd999);
    chk("p7_beats_1000", c7, 32'd999);

    // Reset pulse mid-HIGH with 57 beats counted.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; tvalid = 1'b1; tdata = 16'h1234;
    for (int k = 0; k < 58; k++) step();
    chk("mid_count_57", c1, 32'd57);
    chk("mid_tready_high", 32'(r1), 32'd1);
    rst_n = 1'b0;
    step();
    chk("rst_tready", 32'(r1), 32'd0);
    chk("rst_count", c1, 32'd0);
    chk("rst_last", 32'(l1), 32'd0);
    chk("rst_err", 32'(e1), 32'd0);
    rst_n = 1'b1;
    step();
    chk("restart_tready", 32'(r1), 32'd1);
    chk("restart_count0", c1, 32'd0);
    step();
    chk("restart_count1", c1, 32'd1);
    step();
    chk("restart_count2", c1, 32'd2);

    // Sequence check: 0,2,4,6 clean, then 9 trips it.
    rst_n = 1'b0; tvalid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tdata = 16'(2 * k);
      step();
    end
    chk("seq_clean_count", c1, 32'd4);
    chk("seq_clean_err", 32'(e1), 32'd0);
    tdata = 16'd9;
    step();
    chk("seq_bad_err", 32'(e1), 32'(EN));
    tdata = 16'd11;
    step();
    tdata = 16'd13;
    step();
    chk("seq_sticky_err", 32'(e1), 32'(EN));
    chk("seq_sticky_last", 32'(l1), 32'd13);
    tvalid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("seq_reset_err", 32'(e1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_ready_sink.md
AXIS_READY_SINK -- requirements
Module: axis_ready_sink

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the tdata width in bits.
REQ-002 SHALL have parameter READY_POLICY, default 1, selecting tready behaviour: 0 = always high, 1 = oscillate, 2 = single window.
REQ-003 SHALL have parameter LOW_TIME, default 1, giving the tready-low phase length in cycles (valid range 1..65535).
REQ-004 SHALL have parameter HIGH_TIME, default 200, giving the tready-high phase length in cycles (valid range 1..65535).
REQ-005 SHALL have parameter CHECK_STEP, default 2, giving the expected tdata increment between accepted beats.
REQ-006 aclk  input  1  sole clock; all logic on the rising edge.
REQ-007 aresetn  input  1  reset, synchronous, active-low.
REQ-008 s_axis_tvalid  input  1  upstream beat valid.
REQ-009 s_axis_tready  output  1  sink ready, registered.
REQ-010 s_axis_tdata  input  DATA_WIDTH  beat payload.
REQ-011 beat_count  output  32  number of accepted beats.
REQ-012 last_tdata  output  DATA_WIDTH  payload of the most recent accepted beat.
REQ-013 seq_err  output  1  sticky sequence-error flag.

Function
REQ-014 A beat SHALL be accepted on a rising aclk edge where s_axis_tvalid=1 and s_axis_tready=1; no other condition accepts a beat.
REQ-015 On each accepted beat, beat_count SHALL increment by 1 (wrapping 0xFFFFFFFF->0) and last_tdata SHALL load s_axis_tdata, both visible the cycle after acceptance.
REQ-016 Policy 0: s_axis_tready SHALL be 1 from the first cycle after reset release onward.
REQ-017 Policy 1: s_axis_tready SHALL be 0 for exactly LOW_TIME cycles, then 1 for exactly HIGH_TIME cycles, repeating indefinitely, starting with the low phase at reset release.
REQ-018 Policy 2: s_axis_tready SHALL be 0 for LOW_TIME cycles, then 1 for HIGH_TIME cycles, then remain 1 permanently.
REQ-019 Phase control SHALL be a two-state FSM (LOW, HIGH) with a 16-bit down-counter loaded with the phase length minus 1 on each phase entry; the transition SHALL occur when the counter reaches 0.
REQ-020 The tready schedule SHALL be independent of s_axis_tvalid; the sink SHALL never wait for valid before asserting ready.
REQ-021 Deassertion of tready while tvalid=1 SHALL be permitted; the beat held by upstream SHALL be accepted at the next ready-high edge and SHALL be counted only once.
REQ-022 An unrecognised READY_POLICY value SHALL behave as policy 0.

Reset
REQ-023 While aresetn=0 at a rising edge: s_axis_tready=0, beat_count=0, last_tdata=0, seq_err=0, FSM=LOW with counter=LOW_TIME-1; no beat SHALL be accepted.
REQ-024 Reset asserted mid-phase SHALL abort the phase; after release the schedule SHALL restart from REQ-017/REQ-018 cycle 0.

Configuration
REQ-025 With macro AXIS_SINK_SEQ_CHECK_EN defined, each accepted beat after the first SHALL compare s_axis_tdata against last_tdata+CHECK_STEP (modulo 2^DATA_WIDTH); on a mismatch, seq_err SHALL set the following cycle and stay set until reset.
REQ-026 Without AXIS_SINK_SEQ_CHECK_EN, no comparison logic SHALL exist and seq_err SHALL be tied to 0.

Verification
REQ-027 Policy 1, LOW_TIME=1, HIGH_TIME=200, release reset -> tready 0 for 1 cycle, 1 for 200 cycles, 0 for 1 cycle, repeating; period 201 cycles.
REQ-028 Policy 1, tvalid held 1 for 402 cycles after reset -> beat_count=400.
REQ-029 Policy 2, LOW_TIME=1, HIGH_TIME=100 -> tready 0 for 1 cycle, then 1 permanently; 1000 valid cycles -> beat_count=999.
REQ-030 Check enabled, CHECK_STEP=2, tdata 0,2,4,6 -> seq_err=0; then tdata 9 -> seq_err=1 one cycle later, remaining 1 through further correct beats until reset.
REQ-031 tdata 0xFFFE then 0x0000 with CHECK_STEP=2 -> no error (wrap); with the macro undefined, mismatching data -> seq_err stays 0.
REQ-032 aresetn pulsed low mid-HIGH phase with beat_count=57 -> all outputs 0, tready low phase restarts, beat_count counts from 0.
